// File: rtl/vga_raster_gen_if.sv
// Signal bundle between the raster generator (master) and the framebuffer/pixel stage (slave).
// Carries the frame counter only when VGA_RASTER_FRAME_CNT_EN is defined.
interface vga_raster_gen_if;
   logic       cli;
   logic [5:0] x_hi;
   logic [4:0] x_lo;
   logic [4:0] y_hi;
   logic [5:0] y_lo;
   logic       hsync;
   logic       vsync;
   logic       blank;
   logic       interrupt;
`ifdef VGA_RASTER_FRAME_CNT_EN
   logic [7:0] frame;

   modport master (
      input  cli,
      output x_hi, x_lo, y_hi, y_lo, hsync, vsync, blank, interrupt, frame
   );
   modport slave (
      output cli,
      input  x_hi, x_lo, y_hi, y_lo, hsync, vsync, blank, interrupt, frame
   );
`else
   modport master (
      input  cli,
      output x_hi, x_lo, y_hi, y_lo, hsync, vsync, blank, interrupt
   );
   modport slave (
      output cli,
      input  x_hi, x_lo, y_hi, y_lo, hsync, vsync, blank, interrupt
   );
`endif
endinterface

// File: rtl/vga_raster_gen.sv
// Raster timing generator: 32-pixel columns / 48-line rows, sync, blank and frame interrupt.
// Defining VGA_RASTER_FRAME_CNT_EN adds an 8-bit frame counter output.
module vga_raster_gen #(
   parameter int H_ACTIVE = 1024,
   parameter int V_ACTIVE = 768,
   parameter int H_FP     = 24,
   parameter int H_SYNC   = 136,
   parameter int H_BP     = 160,
   parameter int V_FP     = 3,
   parameter int V_SYNC   = 6,
   parameter int V_BP     = 29
) (
   input logic             clk,
   input logic             rst,
   vga_raster_gen_if.master bus
);

   localparam int HT       = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int VT       = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int HS_START = H_ACTIVE + H_FP;
   localparam int HS_END   = HS_START + H_SYNC;
   localparam int VS_START = V_ACTIVE + V_FP;
   localparam int VS_END   = VS_START + V_SYNC;

   // Every threshold is pre-split into (column,pixel) / (row,line) so no x or y is ever formed
   localparam logic [5:0] XL_HI = 6'((HT - 1) / 32);
   localparam logic [4:0] XL_LO = 5'((HT - 1) % 32);
   localparam logic [5:0] XA_HI = 6'(H_ACTIVE / 32);
   localparam logic [4:0] XA_LO = 5'(H_ACTIVE % 32);
   localparam logic [5:0] XS_HI = 6'(HS_START / 32);
   localparam logic [4:0] XS_LO = 5'(HS_START % 32);
   localparam logic [5:0] XE_HI = 6'(HS_END / 32);
   localparam logic [4:0] XE_LO = 5'(HS_END % 32);
   localparam logic [4:0] YL_HI = 5'((VT - 1) / 48);
   localparam logic [5:0] YL_LO = 6'((VT - 1) % 48);
   localparam logic [4:0] YA_HI = 5'(V_ACTIVE / 48);
   localparam logic [5:0] YA_LO = 6'(V_ACTIVE % 48);
   localparam logic [4:0] YP_HI = 5'((V_ACTIVE - 1) / 48);
   localparam logic [5:0] YP_LO = 6'((V_ACTIVE - 1) % 48);
   localparam logic [4:0] YS_HI = 5'(VS_START / 48);
   localparam logic [5:0] YS_LO = 6'(VS_START % 48);
   localparam logic [4:0] YE_HI = 5'(VS_END / 48);
   localparam logic [5:0] YE_LO = 6'(VS_END % 48);

   function automatic logic geX(input logic [5:0] hi, input logic [4:0] lo,
                                input logic [5:0] cHi, input logic [4:0] cLo);
      return (hi > cHi) || ((hi == cHi) && (lo >= cLo));
   endfunction

   function automatic logic geY(input logic [4:0] hi, input logic [5:0] lo,
                                input logic [4:0] cHi, input logic [5:0] cLo);
      return (hi > cHi) || ((hi == cHi) && (lo >= cLo));
   endfunction

   logic [5:0] xHi_q, xHi_d;
   logic [4:0] xLo_q, xLo_d;
   logic [4:0] yHi_q, yHi_d;
   logic [5:0] yLo_q, yLo_d;
   logic       intr_q, intr_d;
   logic       xLast, yLast, setEv;

   assign xLast = (xHi_q == XL_HI) && (xLo_q == XL_LO);
   assign yLast = (yHi_q == YL_HI) && (yLo_q == YL_LO);
   // Next edge moves the raster onto (0, V_ACTIVE): the first blanked line
   assign setEv = xLast && (yHi_q == YP_HI) && (yLo_q == YP_LO);

   always_comb begin
      xHi_d = xHi_q;
      xLo_d = xLo_q + 5'd1;
      yHi_d = yHi_q;
      yLo_d = yLo_q;
      if (xLast) begin
         xHi_d = '0;
         xLo_d = '0;
         if (yLast) begin
            yHi_d = '0;
            yLo_d = '0;
         end else if (yLo_q == 6'd47) begin
            yHi_d = yHi_q + 5'd1;
            yLo_d = '0;
         end else begin
            yLo_d = yLo_q + 6'd1;
         end
      end else if (xLo_q == 5'd31) begin
         xHi_d = xHi_q + 6'd1;
         xLo_d = '0;
      end
   end

   // A set in the same cycle as cli must win so a frame edge is never lost
   assign intr_d = setEv ? 1'b1 : (bus.cli ? 1'b0 : intr_q);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         xHi_q  <= '0;
         xLo_q  <= '0;
         yHi_q  <= '0;
         yLo_q  <= '0;
         intr_q <= 1'b0;
      end else begin
         xHi_q  <= xHi_d;
         xLo_q  <= xLo_d;
         yHi_q  <= yHi_d;
         yLo_q  <= yLo_d;
         intr_q <= intr_d;
      end
   end

`ifdef VGA_RASTER_FRAME_CNT_EN
   logic [7:0] frame_q, frame_d;

   assign frame_d = setEv ? frame_q + 8'd1 : frame_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) frame_q <= '0;
      else     frame_q <= frame_d;
   end

   assign bus.frame = frame_q;
`endif

   assign bus.x_hi      = xHi_q;
   assign bus.x_lo      = xLo_q;
   assign bus.y_hi      = yHi_q;
   assign bus.y_lo      = yLo_q;
   assign bus.blank     = geX(xHi_q, xLo_q, XA_HI, XA_LO) | geY(yHi_q, yLo_q, YA_HI, YA_LO);
   assign bus.hsync     = !(geX(xHi_q, xLo_q, XS_HI, XS_LO) && !geX(xHi_q, xLo_q, XE_HI, XE_LO));
   assign bus.vsync     = !(geY(yHi_q, yLo_q, YS_HI, YS_LO) && !geY(yHi_q, yLo_q, YE_HI, YE_LO));
   assign bus.interrupt = intr_q;

endmodule
